serializer_mod: RTL

//  Parallel-to-serial converter feeding the 16-bit deserializer stage.

---
 rtl/serializer_mod.sv | 102 ++++++++++
 1 files changed

// File: rtl/serializer_mod.sv
// Parallel-to-serial converter: sends the upper <len> bits of a word MSB-first,
// one bit per clock, with a per-bit valid; back-to-back words run gap-free.
module serializer_mod #(
    parameter  int DATA_W  = 16,
    parameter  int MIN_MOD = 3,
    localparam int MOD_W   = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              srst_n_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o
);

    localparam logic [MOD_W-1:0] MIN_MOD_C = MOD_W'(MIN_MOD);
    localparam logic [MOD_W:0]   FULL_LEN  = (MOD_W+1)'(DATA_W);
    localparam logic [MOD_W:0]   ONE       = (MOD_W+1)'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_q, state_n;
    logic [DATA_W-1:0] shreg_q, shreg_n;
    logic [MOD_W:0]    cnt_q,   cnt_n;
    logic              bit_q,   bit_n;
    logic              val_q,   val_n;

    logic [MOD_W:0]    len_in;
    logic              mod_legal;
    logic              last_bit;
    logic              take;

    assign len_in    = (data_mod_i == '0) ? FULL_LEN : {1'b0, data_mod_i};
    assign mod_legal = (data_mod_i == '0) || (data_mod_i >= MIN_MOD_C);
    // cnt_q counts bits still to present, including the one on the output now
    assign last_bit  = (state_q == SHIFT) && (cnt_q == ONE);
    assign take      = data_val_i && mod_legal && ((state_q == IDLE) || last_bit);

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            shreg_q <= shreg_n;
            cnt_q   <= cnt_n;
            bit_q   <= bit_n;
            val_q   <= val_n;
        end
    end

    always_comb begin
        state_n = state_q;
        shreg_n = shreg_q;
        cnt_n   = cnt_q;
        bit_n   = 1'b0;
        val_n   = 1'b0;

        if (take) begin
            // first bit goes straight to the output register; the rest wait in shreg
            state_n = SHIFT;
            shreg_n = {data_i[DATA_W-2:0], 1'b0};
            cnt_n   = len_in;
            bit_n   = data_i[DATA_W-1];
            val_n   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_n = IDLE;
                end
                SHIFT: begin
                    if (cnt_q != '0) begin
                        cnt_n = cnt_q - ONE;
                    end
                    if (last_bit || cnt_q == '0) begin
                        state_n = IDLE;
                    end else begin
                        bit_n   = shreg_q[DATA_W-1];
                        val_n   = 1'b1;
                        shreg_n = {shreg_q[DATA_W-2:0], 1'b0};
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign ser_data_o     = bit_q;
    assign ser_data_val_o = val_q;
    assign busy_o         = val_q;

endmodule
